// File: rtl/game_input_ctrl_pkg.sv
// Shared constants for the game input stage: FSM state codes and button indices.
// The state encoding is the one the game FSM drives on its output.
package game_input_ctrl_pkg;

   localparam logic [2:0] ST_START    = 3'd0;
   localparam logic [2:0] ST_PLAYING  = 3'd1;
   localparam logic [2:0] ST_PAUSE    = 3'd2;
   localparam logic [2:0] ST_RESET    = 3'd3;
   localparam logic [2:0] ST_GAMEOVER = 3'd4;

   localparam int unsigned BTN_START = 0;
   localparam int unsigned BTN_PAUSE = 1;
   localparam int unsigned BTN_RESET = 2;

   // Pause only has meaning while a game is in progress; all other codes act like START.
   function automatic logic pause_allowed(logic [2:0] state);
      return (state == ST_PLAYING) || (state == ST_PAUSE);
   endfunction

endpackage

// File: rtl/game_input_ctrl_if.sv
// Button/state inputs and conditioned control outputs of the game input stage.
interface game_input_ctrl_if;

   logic       btn_start_n;
   logic       btn_pause_n;
   logic       btn_reset_n;
   logic [2:0] game_state;
   logic       startGame;
   logic       pauseGame;
   logic       resetGame;
   logic [2:0] btn_level;

   modport master (
      output btn_start_n, btn_pause_n, btn_reset_n, game_state,
      input  startGame, pauseGame, resetGame, btn_level
   );

   modport slave (
      input  btn_start_n, btn_pause_n, btn_reset_n, game_state,
      output startGame, pauseGame, resetGame, btn_level
   );

endinterface

// File: rtl/game_input_ctrl_btn_debounce.sv
// One pushbutton channel: 2-flop synchroniser, stable-count debounce, press strobe.
module game_input_ctrl_btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic clk,
   input  logic resetFSM,
   input  logic btn_n,
   output logic level,
   output logic press
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             raw;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign raw = ~sync2_q;

   // Any sample matching the accepted level restarts the stability count.
   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (raw != level_q) begin
         if (cnt_q == LastCnt) begin
            level_d = raw;
            press_d = raw;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge resetFSM) begin
      if (resetFSM) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/game_input_ctrl.sv
// Game input stage top: three debounce channels plus start/reset pulse priority
// and the pause toggle gated by the FSM state.
module game_input_ctrl
   import game_input_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input logic               clk,
   input logic               resetFSM,
   game_input_ctrl_if.slave  bus
);

   logic [2:0] btn_n;
   logic [2:0] level;
   logic [2:0] press;

   logic start_q, start_d;
   logic reset_q, reset_d;
   logic pause_q, pause_d;

   assign btn_n = {bus.btn_reset_n, bus.btn_pause_n, bus.btn_start_n};

   for (genvar i = 0; i < 3; i++) begin : g_btn
      game_input_ctrl_btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk      (clk),
         .resetFSM (resetFSM),
         .btn_n    (btn_n[i]),
         .level    (level[i]),
         .press    (press[i])
      );
   end

   // Reset strobe beats start; a paused game ignores start.
   always_comb begin
      start_d = press[BTN_START] & ~press[BTN_RESET] & ~pause_q;
      reset_d = press[BTN_RESET];
      pause_d = pause_q;
      if (!pause_allowed(bus.game_state) || reset_q) begin
         pause_d = 1'b0;
      end else if (press[BTN_PAUSE]) begin
         pause_d = ~pause_q;
      end
   end

   always_ff @(posedge clk or posedge resetFSM) begin
      if (resetFSM) begin
         start_q <= 1'b0;
         reset_q <= 1'b0;
         pause_q <= 1'b0;
      end else begin
         start_q <= start_d;
         reset_q <= reset_d;
         pause_q <= pause_d;
      end
   end

   assign bus.startGame = start_q;
   assign bus.resetGame = reset_q;
   assign bus.pauseGame = pause_q;
   assign bus.btn_level = level;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed plus randomized checks of game_input_ctrl against a timestamp-based reference model.
module tb_game_input_ctrl;

   localparam int unsigned D = 4;

   logic clk = 1'b0;
   logic resetFSM;

   game_input_ctrl_if bus ();

   game_input_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .clk      (clk),
      .resetFSM (resetFSM),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Reference model: a level is accepted once D consecutive synchronised samples
   // have disagreed with it, measured as time since the last agreeing sample or change.
   logic [2:0] m_s1, m_s2, m_lvl, m_press;
   logic       m_start, m_pause, m_reset;
   int         last_eq [3];
   int         last_chg[3];
   int         t = 0;

   int n_checks = 0;
   int n_err    = 0;
   int start_pulses, reset_pulses, pause_toggles;
   logic lvl0_seen, start_at_reset, prev_pause;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic clear_counts();
      start_pulses   = 0;
      reset_pulses   = 0;
      pause_toggles  = 0;
      lvl0_seen      = 1'b0;
      start_at_reset = 1'b0;
   endtask

   task automatic step();
      logic [2:0] btn, s, pr;
      logic [2:0] st_code;
      logic       st, rs, pa;
      int         since;
      btn     = {bus.btn_reset_n, bus.btn_pause_n, bus.btn_start_n};
      st_code = bus.game_state;
      @(posedge clk);
      t++;
      if (resetFSM) begin
         m_s1 = 3'b111; m_s2 = 3'b111; m_lvl = 3'b000; m_press = 3'b000;
         m_start = 1'b0; m_pause = 1'b0; m_reset = 1'b0;
         for (int b = 0; b < 3; b++) begin
            last_eq[b]  = t;
            last_chg[b] = t;
         end
      end else begin
         s  = ~m_s2;
         pr = 3'b000;
         for (int b = 0; b < 3; b++) begin
            since = (last_eq[b] > last_chg[b]) ? last_eq[b] : last_chg[b];
            if (s[b] == m_lvl[b]) begin
               last_eq[b] = t;
            end else if (t - since >= int'(D)) begin
               m_lvl[b]    = s[b];
               last_chg[b] = t;
               pr[b]       = s[b];
            end
         end
         st = m_press[0] && !m_press[2] && !m_pause;
         rs = m_press[2];
         if (!(st_code == 3'd1 || st_code == 3'd2) || m_reset) pa = 1'b0;
         else if (m_press[1])                                 pa = !m_pause;
         else                                                 pa = m_pause;
         m_start = st; m_reset = rs; m_pause = pa;
         m_press = pr;
         m_s2    = m_s1;
         m_s1    = btn;
      end
      @(negedge clk);
      check("startGame", bus.startGame, m_start);
      check("resetGame", bus.resetGame, m_reset);
      check("pauseGame", bus.pauseGame, m_pause);
      check("btn_level", bus.btn_level, m_lvl);
      if (bus.startGame) start_pulses++;
      if (bus.resetGame) begin
         reset_pulses++;
         if (bus.startGame) start_at_reset = 1'b1;
      end
      if (bus.pauseGame != prev_pause) pause_toggles++;
      prev_pause = bus.pauseGame;
      if (bus.btn_level[0]) lvl0_seen = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int   lat;
      logic pat[5];
      pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      prev_pause      = 1'b0;
      bus.btn_start_n = 1'b1;
      bus.btn_pause_n = 1'b1;
      bus.btn_reset_n = 1'b1;
      bus.game_state  = 3'd0;
      resetFSM        = 1'b1;
      clear_counts();
      run(2);
      check("reset_outputs", {bus.startGame, bus.pauseGame, bus.resetGame, bus.btn_level}, 6'd0);
      resetFSM = 1'b0;
      run(2);

      // Clean start press: latency and single pulse while held
      clear_counts();
      lat = 0;
      bus.btn_start_n = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus.startGame && lat == 0) lat = i;
      end
      check("start_latency", lat, D + 3);
      check("start_single_pulse", start_pulses, 1);
      check("start_level_held", bus.btn_level[0], 1'b1);
      bus.btn_start_n = 1'b1;
      run(10);
      check("start_level_released", bus.btn_level[0], 1'b0);

      // Bouncy pause while playing
      bus.game_state = 3'd1;
      run(2);
      clear_counts();
      for (int i = 0; i < 5; i++) begin
         bus.btn_pause_n = pat[i];
         step();
      end
      check("bounce_no_toggle", pause_toggles, 0);
      bus.btn_pause_n = 1'b0;
      run(12);
      check("bounce_one_toggle", pause_toggles, 1);
      check("bounce_paused", bus.pauseGame, 1'b1);
      bus.btn_pause_n = 1'b1;
      run(10);

      // Second press unpauses, third re-pauses, then RESET state clears it
      bus.btn_pause_n = 1'b0; run(10);
      bus.btn_pause_n = 1'b1; run(10);
      check("pause_toggle_off", bus.pauseGame, 1'b0);
      bus.btn_pause_n = 1'b0; run(10);
      bus.btn_pause_n = 1'b1; run(10);
      check("pause_toggle_on", bus.pauseGame, 1'b1);
      bus.game_state = 3'd3;
      step();
      check("pause_cleared_by_state", bus.pauseGame, 1'b0);

      // Start and reset on the same edge: reset wins
      bus.game_state = 3'd1;
      run(2);
      clear_counts();
      bus.btn_start_n = 1'b0;
      bus.btn_reset_n = 1'b0;
      run(12);
      check("simul_reset_pulses", reset_pulses, 1);
      check("simul_start_pulses", start_pulses, 0);
      check("simul_start_at_reset", start_at_reset, 1'b0);
      bus.btn_start_n = 1'b1;
      bus.btn_reset_n = 1'b1;
      run(10);

      // Start ignored while paused
      bus.game_state = 3'd2;
      bus.btn_pause_n = 1'b0; run(12);
      bus.btn_pause_n = 1'b1; run(10);
      check("paused_for_start", bus.pauseGame, 1'b1);
      clear_counts();
      bus.btn_start_n = 1'b0; run(12);
      check("paused_start_pulses", start_pulses, 0);
      check("paused_start_level", lvl0_seen, 1'b1);
      bus.btn_start_n = 1'b1; run(10);

      // resetFSM mid-debounce of a reset press
      bus.game_state = 3'd1;
      bus.btn_reset_n = 1'b0;
      run(4);
      resetFSM = 1'b1;
      clear_counts();
      for (int i = 0; i < 3; i++) begin
         step();
         check("outputs_in_reset",
               {bus.startGame, bus.pauseGame, bus.resetGame, bus.btn_level}, 6'd0);
      end
      resetFSM = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus.resetGame && lat == 0) lat = i;
      end
      check("reset_after_rst_latency", lat, D + 3);
      check("reset_after_rst_pulses", reset_pulses, 1);
      bus.btn_reset_n = 1'b1;
      run(10);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(5) == 0) bus.btn_start_n = ~bus.btn_start_n;
         if ($urandom_range(5) == 0) bus.btn_pause_n = ~bus.btn_pause_n;
         if ($urandom_range(7) == 0) bus.btn_reset_n = ~bus.btn_reset_n;
         if ($urandom_range(19) == 0) bus.game_state = 3'($urandom_range(7));
         resetFSM = ($urandom_range(299) == 0);
         step();
      end
      resetFSM = 1'b0;
      run(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
